// File: rtl/demux_slot_seq.sv
// Upstream sequencer for a 1:4 bit demux: accepts a 4-bit word and channel mask,
// then plays it out as four HOLD_CYC-long slots on the demux select/data/enable lines.
module demux_slot_seq #(
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [3:0] in_mask,
  input  logic       flush,
  output logic       s0,
  output logic       s1,
  output logic       I,
  output logic       en,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned     CH_W      = 2;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(3);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic              i_q, i_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_c;
  logic              accept_c;
  logic              slot_c;

  // Next-state and next-output logic; outputs are derived from the next state so
  // the registered copies line up with the slot they describe.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    hold_d   = hold_q;
    data_d   = data_q;
    mask_d   = mask_q;
    last_c   = (state_q == SLOT) && (ch_q == CH_LAST) && (hold_q == HOLD_LAST);
    in_ready = (state_q == IDLE) || last_c;
    accept_c = in_valid && in_ready && !flush;

    if (flush) begin
      state_d = IDLE;
      ch_d    = '0;
      hold_d  = '0;
    end else if (accept_c) begin
      state_d = SLOT;
      data_d  = in_data;
      mask_d  = in_mask;
      ch_d    = '0;
      hold_d  = '0;
    end else if (state_q == SLOT) begin
      if (last_c) begin
        state_d = IDLE;
        ch_d    = '0;
        hold_d  = '0;
      end else if (hold_q == HOLD_LAST) begin
        ch_d   = CH_W'(ch_q + CH_W'(1));
        hold_d = '0;
      end else begin
        hold_d = HOLD_W'(hold_q + HOLD_W'(1));
      end
    end

    slot_c = (state_d == SLOT);
    s0_d   = slot_c && ch_d[1];
    s1_d   = slot_c && ch_d[0];
    en_d   = slot_c && mask_d[ch_d];
    i_d    = slot_c && mask_d[ch_d] && data_d[ch_d];
    busy_d = slot_c;
    done_d = slot_c && (ch_d == CH_LAST) && (hold_d == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      i_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      i_q     <= i_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s0         = s0_q;
  assign s1         = s1_q;
  assign I          = i_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_slot_seq.sv
// Directed scoreboard bench for demux_slot_seq; one instance with HOLD_CYC=1,
// one with HOLD_CYC=3.
module tb_demux_slot_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, f1, rdy1, s0_1, s1_1, i_1, en_1, busy1, fd1;
  logic [3:0] d1, m1;
  logic       v3, f3, rdy3, s0_3, s1_3, i_3, en_3, busy3, fd3;
  logic [3:0] d3, m3;

  demux_slot_seq #(.HOLD_CYC(1), .HOLD_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_mask(m1), .flush(f1), .s0(s0_1), .s1(s1_1), .I(i_1), .en(en_1),
    .busy(busy1), .frame_done(fd1));

  demux_slot_seq #(.HOLD_CYC(3), .HOLD_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .in_mask(m3), .flush(f3), .s0(s0_3), .s1(s1_3), .I(i_3), .en(en_3),
    .busy(busy3), .frame_done(fd3));

  int checks = 0;
  int errors = 0;
  // Entry layout: {in_ready, s0, s1, I, en, busy, frame_done}
  logic [6:0] q[$];
  localparam logic [6:0] IDLE_EXP = 7'b100_0000;

  function automatic logic [6:0] obs1();
    return {rdy1, s0_1, s1_1, i_1, en_1, busy1, fd1};
  endfunction
  function automatic logic [6:0] obs3();
    return {rdy3, s0_3, s1_3, i_3, en_3, busy3, fd3};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference model: expected per-cycle outputs of one frame.
  task automatic push_frame(input int h, input logic [3:0] data, input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < h; c++) begin
        logic last;
        logic [1:0] kk;
        kk   = 2'(k);
        last = (k == 3) && (c == h - 1);
        q.push_back({last, kk[1], kk[0], data[k] & mask[k], mask[k], 1'b1, last});
      end
  endtask

  task automatic pop_chk1(input string tag);
    logic [6:0] e;
    if (q.size() == 0) begin
      chk({tag, "_empty"}, obs1(), 7'bx);
    end else begin
      e = q.pop_front();
      chk(tag, obs1(), e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 0; f1 = 0; d1 = 0; m1 = 0;
    v3 = 0; f3 = 0; d3 = 0; m3 = 0;
    tick();
    tick();
    chk("reset_u1", obs1(), IDLE_EXP);
    chk("reset_u3", obs3(), IDLE_EXP);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", obs1(), IDLE_EXP);

    // HOLD_CYC=1, data 1010 mask 1111
    v1 = 1; d1 = 4'b1010; m1 = 4'b1111;
    push_frame(1, 4'b1010, 4'b1111);
    tick();
    v1 = 0;
    for (int i = 0; i < 4; i++) begin
      pop_chk1("t2_slot");
      tick();
    end
    chk("t2_idle", obs1(), IDLE_EXP);

    // Partial mask
    v1 = 1; d1 = 4'b1111; m1 = 4'b0101;
    push_frame(1, 4'b1111, 4'b0101);
    tick();
    v1 = 0;
    for (int i = 0; i < 4; i++) begin
      pop_chk1("t3_slot");
      tick();
    end
    chk("t3_idle", obs1(), IDLE_EXP);

    // All-masked frame still runs four silent slots and pulses frame_done
    v1 = 1; d1 = 4'b1111; m1 = 4'b0000;
    push_frame(1, 4'b1111, 4'b0000);
    tick();
    v1 = 0;
    for (int i = 0; i < 4; i++) begin
      pop_chk1("mask0_slot");
      tick();
    end
    chk("mask0_idle", obs1(), IDLE_EXP);

    // Back-to-back frames with in_valid held high
    v1 = 1; d1 = 4'b0001; m1 = 4'b1111;
    push_frame(1, 4'b0001, 4'b1111);
    push_frame(1, 4'b1000, 4'b1111);
    tick();
    d1 = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      pop_chk1("t4_slot");
      tick();
      if (i == 3) v1 = 0;
    end
    chk("t4_idle", obs1(), IDLE_EXP);

    // HOLD_CYC=3 on the second instance
    v3 = 1; d3 = 4'b0100; m3 = 4'b1111;
    push_frame(3, 4'b0100, 4'b1111);
    tick();
    v3 = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t5_slot", obs3(), q.pop_front());
      tick();
    end
    chk("t5_idle", obs3(), IDLE_EXP);

    // flush alone during slot 2
    v1 = 1; d1 = 4'b1111; m1 = 4'b1111;
    push_frame(1, 4'b1111, 4'b1111);
    tick();
    v1 = 0;
    pop_chk1("t6a_slot0");
    tick();
    pop_chk1("t6a_slot1");
    tick();
    pop_chk1("t6a_slot2");
    f1 = 1;
    tick();
    f1 = 0;
    q.delete();
    chk("t6a_flushed", obs1(), IDLE_EXP);
    tick();
    chk("t6a_stays_idle", obs1(), IDLE_EXP);

    // flush with in_valid in slot 2
    v1 = 1; d1 = 4'b0110; m1 = 4'b1111;
    push_frame(1, 4'b0110, 4'b1111);
    tick();
    v1 = 0;
    pop_chk1("t6b_slot0");
    tick();
    pop_chk1("t6b_slot1");
    tick();
    pop_chk1("t6b_slot2");
    f1 = 1; v1 = 1; d1 = 4'b1111;
    tick();
    f1 = 0; v1 = 0;
    q.delete();
    chk("t6b_flushed", obs1(), IDLE_EXP);
    tick();
    chk("t6b_no_capture", obs1(), IDLE_EXP);

    // flush on an IDLE accept: flush wins, nothing captured
    v1 = 1; f1 = 1; d1 = 4'b1111; m1 = 4'b1111;
    tick();
    v1 = 0; f1 = 0;
    chk("flush_accept_idle", obs1(), IDLE_EXP);

    // Asynchronous reset mid-frame
    v1 = 1; d1 = 4'b1111; m1 = 4'b1111;
    push_frame(1, 4'b1111, 4'b1111);
    tick();
    v1 = 0;
    pop_chk1("t1_slot0");
    tick();
    pop_chk1("t1_slot1");
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("t1_async_reset", obs1() & 7'b011_1111, 7'b000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t1_after_release", obs1(), IDLE_EXP);
    tick();
    chk("t1_no_frame_done", obs1(), IDLE_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
